// File: rtl/flex_counter_if.sv
// flex_counter_if -- control/status bundle for flex_counter.
//   clear         : synchronous clear request         (master -> slave)
//   count_enable  : advance the count by one per clock (master -> slave)
//   rollover_val  : terminal count, 0 parks the counter (master -> slave)
//   count_out     : registered current count          (slave -> master)
//   rollover_flag : registered, high at a nonzero terminal count (slave -> master)
interface flex_counter_if #(
    parameter int NUM_CNT_BITS = 4
);
    logic                    clear;
    logic                    count_enable;
    logic [NUM_CNT_BITS-1:0] rollover_val;
    logic [NUM_CNT_BITS-1:0] count_out;
    logic                    rollover_flag;

    modport master (
        output clear,
        output count_enable,
        output rollover_val,
        input  count_out,
        input  rollover_flag
    );

    modport slave (
        input  clear,
        input  count_enable,
        input  rollover_val,
        output count_out,
        output rollover_flag
    );
endinterface

// File: rtl/flex_counter.sv
// flex_counter -- parameterisable up-counter that wraps to 1 at rollover_val.
//   clk   : single clock, rising edge
//   n_rst : asynchronous active-high reset (clears count and flag at once)
//   bus   : flex_counter_if slave modport carrying clear, count_enable,
//           rollover_val in and count_out, rollover_flag out
// Both outputs come straight from flops; rollover_val is used unregistered
// at every edge so a change takes effect on the very next clock.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    flex_counter_if.slave bus
);
    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;
    logic                    flag_q;
    logic                    flag_d;

    always_comb begin
        count_d = count_q;
        if (bus.clear) begin
            count_d = '0;
        end else if (bus.rollover_val == '0) begin
            // A zero terminal count parks the counter at 0 whatever the enable.
            count_d = '0;
        end else if (bus.count_enable) begin
            // Wrap to 1 (not 0) also when rollover_val drops below the count;
            // count_q < rollover_val guarantees the increment cannot overflow.
            if (count_q < bus.rollover_val) begin
                count_d = count_q + 1'b1;
            end else begin
                count_d = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};
            end
        end
        // Flag is computed from the next count so it registers alongside it.
        flag_d = (count_d == bus.rollover_val) && (bus.rollover_val != '0);
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign bus.count_out     = count_q;
    assign bus.rollover_flag = flag_q;
endmodule

// File: tb/tb_flex_counter.sv
// tb_flex_counter -- directed self-checking bench for flex_counter
// (NUM_CNT_BITS = 4). Expected values are hand-computed constants.
module tb_flex_counter;
    localparam int NUM_CNT_BITS = 4;

    logic tb_clk;
    logic n_rst;
    int unsigned n_compared;
    int unsigned n_mismatched;

    flex_counter_if #(.NUM_CNT_BITS(NUM_CNT_BITS)) bus ();

    flex_counter #(.NUM_CNT_BITS(NUM_CNT_BITS)) dut (
        .clk   (tb_clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    initial begin
        tb_clk = 1'b0;
        forever #5 tb_clk = ~tb_clk;
    end

    task automatic check_val(input string tag, input int unsigned observed,
                             input int unsigned expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int unsigned exp_cnt,
                             input int unsigned exp_flag);
        check_val({tag, "_cnt"}, int'(bus.count_out), exp_cnt);
        check_val({tag, "_flag"}, int'(bus.rollover_flag), exp_flag);
    endtask

    task automatic pulse_reset();
        n_rst = 1'b1;
        #1;
        n_rst = 1'b0;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        n_rst            = 1'b1;
        bus.clear        = 1'b0;
        bus.count_enable = 1'b0;
        bus.rollover_val = 4'd2;

        // Reset state, held across an edge
        #3;
        check_out("rst_init", 0, 0);
        tick();
        check_out("rst_held", 0, 0);
        n_rst = 1'b0;

        // Wrap scenario, rollover_val = 2
        bus.count_enable = 1'b1;
        tick(); check_out("wrap1", 1, 0);
        tick(); check_out("wrap2", 2, 1);
        tick(); check_out("wrap3", 1, 0);
        tick(); check_out("wrap4", 2, 1);
        bus.count_enable = 1'b0;
        tick(); check_out("hold1", 2, 1);
        tick(); check_out("hold2", 2, 1);

        // Clear beats count_enable
        bus.clear        = 1'b1;
        bus.count_enable = 1'b1;
        tick(); check_out("clear", 0, 0);
        bus.clear = 1'b0;
        tick(); check_out("post_clear", 1, 0);

        // Asynchronous reset mid-cycle, enable still high
        #2;
        n_rst = 1'b1;
        #1;
        check_out("rst_async", 0, 0);
        tick(); check_out("rst_over_en", 0, 0);
        n_rst = 1'b0;
        tick(); check_out("rst_resume", 1, 0);

        // Large rollover, rollover_val = 8
        pulse_reset();
        bus.rollover_val = 4'd8;
        for (int i = 1; i <= 7; i++) begin
            tick(); check_out($sformatf("big%0d", i), i, 0);
        end
        tick(); check_out("big8", 8, 1);
        tick(); check_out("big_w1", 1, 0);
        tick(); check_out("big_w2", 2, 0);
        tick(); check_out("big_w3", 3, 0);

        // Unity rollover
        pulse_reset();
        bus.rollover_val = 4'd1;
        tick(); check_out("unity1", 1, 1);
        tick(); check_out("unity2", 1, 1);
        tick(); check_out("unity3", 1, 1);
        bus.clear = 1'b1;
        tick(); check_out("unity_clr", 0, 0);
        bus.clear = 1'b0;

        // Lowered rollover and zero rollover
        bus.rollover_val = 4'd8;
        for (int i = 1; i <= 5; i++) tick();
        check_out("edge_at5", 5, 0);
        bus.rollover_val = 4'd3;
        tick(); check_out("edge_lower", 1, 0);
        tick(); check_out("edge_inc", 2, 0);
        bus.rollover_val = 4'd0;
        tick(); check_out("edge_zero", 0, 0);
        tick(); check_out("edge_zero2", 0, 0);
        bus.count_enable = 1'b0;
        bus.rollover_val = 4'd3;
        tick(); check_out("edge_hold0", 0, 0);

        // Full-width rollover: 15 is the top value, no wrap through 16
        bus.rollover_val = 4'd15;
        bus.count_enable = 1'b1;
        for (int i = 1; i <= 14; i++) tick();
        check_out("max14", 14, 0);
        tick(); check_out("max15", 15, 1);
        tick(); check_out("max_wrap", 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/flex_counter.md
FLEX_COUNTER -- requirements
Module: flex_counter

Interface
REQ-001 The module SHALL have parameter NUM_CNT_BITS, default 4, setting the width of count_out and rollover_val; it SHALL be legal for any value 1..32.
REQ-002 The module SHALL have input clk, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have input n_rst, 1 bit, the reset; it is asynchronous and active-high: asserted at 1, released at 0.
REQ-004 The module SHALL have input clear, 1 bit, a synchronous counter clear.
REQ-005 The module SHALL have input count_enable, 1 bit, which advances the count by one per enabled clock.
REQ-006 The module SHALL have input rollover_val, NUM_CNT_BITS bits, the terminal count value, sampled every cycle.
REQ-007 The module SHALL have output count_out, NUM_CNT_BITS bits, the registered current count.
REQ-008 The module SHALL have output rollover_flag, 1 bit, registered and high while count_out equals a nonzero rollover_val.

Function
REQ-009 count_out and rollover_flag SHALL both be driven directly from flip-flops, with no combinational path from inputs to outputs.
REQ-010 Per rising edge, next-state priority SHALL be: clear, then count_enable, then hold.
REQ-011 When clear=1, the next count_out SHALL be 0 regardless of count_enable or rollover_val.
REQ-012 When clear=0 and count_enable=0, count_out SHALL hold its value.
REQ-013 When clear=0, count_enable=1 and count_out < rollover_val, the next count_out SHALL be count_out+1.
REQ-014 When clear=0, count_enable=1, rollover_val != 0 and count_out >= rollover_val, the next count_out SHALL be 1, not 0; this also covers rollover_val being lowered below the current count.
REQ-015 When rollover_val = 0 and clear=0, the next count_out SHALL be 0 and rollover_flag SHALL be 0.
REQ-016 The next rollover_flag SHALL equal (next count_out == rollover_val) AND (rollover_val != 0), evaluated against the rollover_val present at that edge.
REQ-017 rollover_flag SHALL therefore rise in the same cycle count_out reaches rollover_val, and SHALL remain high while the count holds there with count_enable=0.
REQ-018 With rollover_val = 1 and count_enable=1, count_out SHALL stay at 1 and rollover_flag SHALL stay at 1 on every cycle after the first increment.
REQ-019 Arithmetic SHALL be unsigned NUM_CNT_BITS wide; count_out SHALL never exceed max(rollover_val, its prior value) and SHALL never wrap through 2^NUM_CNT_BITS.
REQ-020 Changes to rollover_val SHALL take effect at the next clock edge with no pipeline delay.

Reset
REQ-021 While n_rst=1, count_out SHALL be 0 and rollover_flag SHALL be 0, immediately and without waiting for a clock edge.
REQ-022 Reset SHALL override clear and count_enable and SHALL abort any count in progress.
REQ-023 On the first rising edge after n_rst falls to 0, normal function SHALL resume from count 0, so with count_enable=1 count_out becomes 1.

Verification
REQ-024 Reset scenario: with rollover_val=2 and count_enable=1, assert n_rst=1 mid-cycle -> count_out=0 and rollover_flag=0 before the next edge.
REQ-025 Wrap scenario: rollover_val=2, count_enable=1 from count 0 -> count_out sequence 1,2,1,2 with rollover_flag 0,1,0,1; then count_enable=0 -> count_out holds at 2 with rollover_flag=1.
REQ-026 Clear scenario: with count_out=2 and rollover_flag=1, assert clear=1 with count_enable=1 -> count_out=0 and rollover_flag=0; release clear -> count_out=1.
REQ-027 Large rollover scenario: rollover_val=8, count from 0 -> 7 after 7 edges with flag=0, 8 on the 8th edge with flag=1, then 1,2,3 on the following three edges.
REQ-028 Unity rollover scenario: rollover_val=1, count_enable=1 after reset -> count_out=1 and rollover_flag=1 held on consecutive edges; clear=1 -> count_out=0 and rollover_flag=0.
REQ-029 Edge-case scenario: with count_out=5, set rollover_val=3 with count_enable=1 -> count_out=1 and rollover_flag=0; set rollover_val=0 -> count_out=0 and rollover_flag=0.
